shift_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `lshifter_32` left-shift datapath between two requesters. Example requesters are the ALU shift path and the store-byte alignment path. The block accepts one shift request at a time over a valid/ready handshake, evaluates it through the shared shifter, holds the registered result until the owning requester takes it, and counts completed operations.

---
 rtl/shift_arbiter_pkg.sv | 18 +
 rtl/lshifter_32.sv | 11 +
 rtl/shift_arbiter.sv | 95 +++++++++
 tb/tb_shift_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the two-port shift arbiter: FSM encoding,
// port indices and a small one-hot helper.
package shift_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  // One-hot response-valid pattern for a port index.
  function automatic logic [1:0] port_onehot(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lshifter_32.sv
// Combinational 32-bit logical left shifter: zeros fill from bit 0,
// bits pushed past bit 31 are dropped.
module lshifter_32 (
  input  logic [31:0] x_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] z_o
);

  assign z_o = x_i << shamt_i;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sequencer sharing one lshifter_32 between two requesters.
// Accepts one request at a time, holds the registered result until the
// owning port takes it, and counts completed response handshakes.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req_x0,
  input  logic [31:0]      req_x1,
  input  logic [4:0]       req_shamt0,
  input  logic [4:0]       req_shamt1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_z,
  output logic [CNT_W-1:0] op_count
);

  state_e           state_q;
  logic             owner_q;
  logic             last_q;
  logic [1:0]       rsp_valid_q;
  logic [31:0]      rsp_z_q;
  logic [CNT_W-1:0] op_count_q;

  logic        rsp_done;
  logic        can_accept;
  logic [1:0]  arb_mask;
  logic        accept;
  logic        grant;
  logic [31:0] sh_x_d;
  logic [4:0]  sh_amt_d;
  logic [31:0] sh_z;

  // Per-port eligibility. Each bit looks only at the other port's valid so
  // a port's ready never loops back through its own valid. With both valid,
  // the port that did not win last time goes first.
  function automatic logic [1:0] arb_ready(input logic [1:0] v, input logic last);
    logic [1:0] r;
    r[P0] = ~v[P1] | (last == P1);
    r[P1] = ~v[P0] | (last == P0);
    return r;
  endfunction

  // Owner takes its result this cycle; the slot is then free to refill.
  assign rsp_done   = (state_q == ST_HOLD) && rsp_ready[owner_q];
  assign can_accept = !rst && ((state_q == ST_IDLE) || rsp_done);
  assign arb_mask   = arb_ready(req_valid, last_q);
  assign req_ready  = can_accept ? arb_mask : 2'b00;
  assign accept     = |(req_valid & req_ready);
  assign grant      = req_valid[P1] & req_ready[P1];

  // Shared shifter input follows the granted port.
  assign sh_x_d   = grant ? req_x1     : req_x0;
  assign sh_amt_d = grant ? req_shamt1 : req_shamt0;

  lshifter_32 u_shift (
    .x_i     (sh_x_d),
    .shamt_i (sh_amt_d),
    .z_o     (sh_z)
  );

  // FSM plus registered outputs: load on accept, drain on owner handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= P0;
      last_q      <= P1;
      rsp_valid_q <= 2'b00;
      rsp_z_q     <= '0;
      op_count_q  <= '0;
    end else begin
      if (rsp_done) op_count_q <= op_count_q + CNT_W'(1);
      if (accept) begin
        state_q     <= ST_HOLD;
        owner_q     <= grant;
        last_q      <= grant;
        rsp_valid_q <= port_onehot(grant);
        rsp_z_q     <= sh_z;
      end else if (rsp_done) begin
        state_q     <= ST_IDLE;
        rsp_valid_q <= 2'b00;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_z     = rsp_z_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, all
// compared against a transaction-level model of the arbiter.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_ready2;
  logic [31:0] req_x0, req_x1;
  logic [4:0]  req_shamt0, req_shamt1;
  logic [1:0]  rsp_valid, rsp_valid2, rsp_ready;
  logic [31:0] rsp_z, rsp_z2;
  logic [15:0] op_count;
  logic [1:0]  op_count2;

  always #5 clk = ~clk;

  shift_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_x1(req_x1), .req_shamt0(req_shamt0), .req_shamt1(req_shamt1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .op_count(op_count)
  );

  // Narrow-counter copy on the same stimulus, for wrap behaviour.
  shift_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
    .req_x0(req_x0), .req_x1(req_x1), .req_shamt0(req_shamt0), .req_shamt1(req_shamt1),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_z(rsp_z2), .op_count(op_count2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction model: one pending result slot, round-robin memory, counter.
  bit          m_pend, m_own, m_last;
  logic [31:0] m_z;
  int unsigned m_cnt;
  bit          m_acc, m_g;
  bit          g_log[$];

  function automatic logic [31:0] shl(input logic [31:0] x, input logic [4:0] s);
    longint unsigned p;
    p = 64'(x) * (64'd1 << s);
    return p[31:0];
  endfunction

  task automatic reset_model();
    m_pend = 0; m_own = 0; m_last = 1; m_z = '0; m_cnt = 0;
  endtask

  // One clock: check ready before the edge, advance model, check outputs.
  task automatic step();
    bit can, g, done;
    #3;
    can   = !rst && (!m_pend || rsp_ready[m_own]);
    g     = (req_valid == 2'b11) ? !m_last : req_valid[1];
    m_acc = can && (req_valid != 2'b00);
    m_g   = g;
    if (!can) chk("req_ready_blocked", 32'(req_ready), 32'd0);
    else begin
      for (int i = 0; i < 2; i++)
        if (req_valid[i]) chk($sformatf("req_ready%0d", i), 32'(req_ready[i]), 32'(g == i));
    end
    done = m_pend && rsp_ready[m_own];
    if (rst) reset_model();
    else begin
      if (done) m_cnt++;
      if (m_acc) begin
        m_pend = 1; m_own = g; m_last = g;
        m_z = g ? shl(req_x1, req_shamt1) : shl(req_x0, req_shamt0);
        g_log.push_back(g);
      end else if (done) m_pend = 0;
    end
    @(posedge clk); #1;
    chk("rsp_valid", 32'(rsp_valid), m_pend ? (m_own ? 32'd2 : 32'd1) : 32'd0);
    if (m_pend) chk("rsp_z", rsp_z, m_z);
    chk("op_count", 32'(op_count), 32'(m_cnt[15:0]));
    chk("op_count_w2", 32'(op_count2), 32'(m_cnt[1:0]));
  endtask

  task automatic do_reset();
    rst = 1; req_valid = 2'b11; rsp_ready = 2'b00;
    step();
    chk("rst_rsp_z", rsp_z, 32'd0);
    rst = 0; req_valid = 2'b00;
  endtask

  initial begin
    rst = 1; req_valid = 0; rsp_ready = 0;
    req_x0 = 0; req_x1 = 0; req_shamt0 = 0; req_shamt1 = 0;
    reset_model();
    @(posedge clk); #1;
    do_reset();

    // Single request, owner stalls three cycles
    req_valid = 2'b01; req_x0 = 32'h0000_00ab; req_shamt0 = 3;
    step();
    req_valid = 2'b00;
    chk("single_z", rsp_z, 32'h0000_0558);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("single_hold_z", rsp_z, 32'h0000_0558);
    end
    rsp_ready = 2'b01;
    step();
    chk("single_cnt", 32'(op_count), 32'd1);

    // Contention right after reset: port 0 first
    do_reset();
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    req_x0 = 32'h0000_00ab; req_shamt0 = 6;
    req_x1 = 32'h8000_0d2c; req_shamt1 = 8;
    step();
    chk("cont_first", rsp_z, 32'h0000_2ac0);
    req_valid = 2'b10;
    step();
    chk("cont_second", rsp_z, 32'h000d_2c00);
    chk("cont_owner", 32'(rsp_valid), 32'd2);
    req_valid = 2'b00;
    step();

    // Back-to-back on port 1
    rsp_ready = 2'b10; req_valid = 2'b10;
    req_x1 = 32'h8000_00ab; req_shamt1 = 3;
    step();
    chk("b2b_first", rsp_z, 32'h0000_0558);
    req_x1 = 32'h8000_0d2c; req_shamt1 = 9;
    step();
    chk("b2b_second", rsp_z, 32'h001a_5800);
    chk("b2b_valid", 32'(rsp_valid), 32'd2);
    req_valid = 2'b00;
    step();

    // Fairness over ten operations
    do_reset();
    g_log.delete();
    rsp_ready = 2'b11; req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      req_x0 = $urandom; req_x1 = $urandom;
      req_shamt0 = 5'($urandom_range(0, 31)); req_shamt1 = 5'($urandom_range(0, 31));
      step();
    end
    req_valid = 2'b00;
    step();
    chk("fair_cnt", 32'(op_count), 32'd10);
    chk("fair_len", 32'(g_log.size()), 32'd10);
    foreach (g_log[i]) chk($sformatf("fair_grant%0d", i), 32'(g_log[i]), 32'(i % 2));

    // Boundary shift amounts
    req_valid = 2'b01; req_x0 = 32'hffff_ffff; req_shamt0 = 0;
    step();
    chk("shamt0", rsp_z, 32'hffff_ffff);
    req_x0 = 32'h0000_0003; req_shamt0 = 31;
    step();
    chk("shamt31", rsp_z, 32'h8000_0000);
    req_valid = 2'b00;
    step();

    // Reset while holding a result
    rsp_ready = 2'b00; req_valid = 2'b01; req_x0 = 32'h1234_5678; req_shamt0 = 4;
    step();
    req_valid = 2'b00;
    rst = 1;
    step();
    rst = 0;
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_cnt", 32'(op_count), 32'd0);

    // Five completions wrap the 2-bit counter to 1
    rsp_ready = 2'b11; req_valid = 2'b01;
    for (int i = 0; i < 5; i++) step();
    req_valid = 2'b00;
    step();
    chk("wrap_cnt2", 32'(op_count2), 32'd1);
    chk("wrap_cnt16", 32'(op_count), 32'd5);

    // Randomized traffic; requesters hold operands until accepted
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        bool_upd(i);
      end
      rsp_ready = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Refresh a port's request when idle or just accepted.
  task automatic bool_upd(input int i);
    if (!req_valid[i] || (m_acc && m_g == i) || rst) begin
      req_valid[i] = ($urandom_range(0, 3) != 0);
      if (i == 0) begin
        req_x0 = $urandom; req_shamt0 = 5'($urandom_range(0, 31));
      end else begin
        req_x1 = $urandom; req_shamt1 = 5'($urandom_range(0, 31));
      end
    end
  endtask

endmodule
